// File: rtl/tsp16_pkg.sv
// Shared definitions for the 16-bit pipeline: opcode constants, opcode
// field helper and the memory-stage FSM state type.
package tsp16_pkg;

  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } mau_state_t;

  // Major opcode lives in the top nibble of every instruction word.
  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Memory-stage load/store initiator. Issues stores in the same cycle the
// execute bundle arrives, issues loads to a synchronous-read memory and
// stalls execute for the one cycle the read data takes to come back.
// Every instruction leaves as a registered memory-stage bundle.
//
// Optional build macro MAU_FAULT_EN: loads/stores above MEM_TOP are
// suppressed and flagged on mem_fault instead of reaching memory.
module mem_access_unit
  import tsp16_pkg::*;
#(
  parameter int              AW      = 16,
  parameter int              DW      = 16,
  parameter logic [AW-1:0]   MEM_TOP = AW'(16'hFFFF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          execute_done,
  input  logic          execute_is_dependent,
  input  logic [DW-1:0] execute_result,
  input  logic [15:0]   execute_instr,
  input  logic [DW-1:0] execute_store_data,
  input  logic [DW-1:0] mem_read_output,
  output logic          mem_write,
  output logic [AW-1:0] mem_write_address,
  output logic [DW-1:0] mem_write_input,
  output logic [AW-1:0] mem_read_address,
  output logic          memory_stall,
  output logic          memory_done,
  output logic          memory_is_dependent,
  output logic [DW-1:0] memory_result,
  output logic [15:0]   memory_instr,
  output logic          mem_fault
);

  mau_state_t    state, state_next;

  // Load context held across the wait cycle.
  logic [AW-1:0] ld_addr, ld_addr_next;
  logic [15:0]   ld_instr, ld_instr_next;
  logic          ld_dep, ld_dep_next;

  logic          done_next, dep_next, fault_next;
  logic [DW-1:0] result_next;
  logic [15:0]   instr_next;

  logic [AW-1:0] exec_addr;
  logic          is_ldr, is_str, addr_fault;

  assign exec_addr = AW'(execute_result);
  assign is_ldr    = (opcode_of(execute_instr) == OP_LDR);
  assign is_str    = (opcode_of(execute_instr) == OP_STR);

`ifdef MAU_FAULT_EN
  assign addr_fault = (exec_addr > MEM_TOP);
`else
  assign addr_fault = 1'b0;
`endif

  // Next-state, next-bundle and combinational memory-port decode.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave one unassigned and infer a latch.
    state_next        = state;
    ld_addr_next      = ld_addr;
    ld_instr_next     = ld_instr;
    ld_dep_next       = ld_dep;
    done_next         = 1'b0;
    dep_next          = memory_is_dependent;
    result_next       = memory_result;
    instr_next        = memory_instr;
    fault_next        = 1'b0;
    mem_write         = 1'b0;
    mem_write_address = '0;
    mem_write_input   = '0;
    mem_read_address  = '0;
    memory_stall      = 1'b0;

    case (state)
      IDLE: begin
        if (execute_done) begin
          if ((is_ldr || is_str) && addr_fault) begin
            // Out-of-range access: no memory traffic, emit a flagged bundle.
            done_next   = 1'b1;
            dep_next    = 1'b0;
            result_next = '0;
            instr_next  = execute_instr;
            fault_next  = 1'b1;
          end else if (is_str) begin
            mem_write         = 1'b1;
            mem_write_address = exec_addr;
            mem_write_input   = execute_store_data;
            done_next         = 1'b1;
            dep_next          = 1'b0;
            result_next       = execute_result;
            instr_next        = execute_instr;
          end else if (is_ldr) begin
            mem_read_address = exec_addr;
            memory_stall     = 1'b1;
            ld_addr_next     = exec_addr;
            ld_instr_next    = execute_instr;
            ld_dep_next      = execute_is_dependent;
            state_next       = LOAD_WAIT;
          end else begin
            done_next   = 1'b1;
            dep_next    = execute_is_dependent;
            result_next = execute_result;
            instr_next  = execute_instr;
          end
        end
      end

      LOAD_WAIT: begin
        // Read data is valid now; the held execute bundle is the same load
        // and is deliberately ignored.
        mem_read_address = ld_addr;
        done_next        = 1'b1;
        dep_next         = ld_dep;
        result_next      = mem_read_output;
        instr_next       = ld_instr;
        state_next       = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Memory ports and stall stay quiet while reset is asserted.
    if (reset) begin
      mem_write         = 1'b0;
      mem_write_address = '0;
      mem_write_input   = '0;
      mem_read_address  = '0;
      memory_stall      = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory-stage bundle and load-context registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memory_done         <= 1'b0;
      memory_is_dependent <= 1'b0;
      memory_result       <= '0;
      memory_instr        <= '0;
      ld_addr             <= '0;
      ld_instr            <= '0;
      ld_dep              <= 1'b0;
    end else begin
      memory_done         <= done_next;
      memory_is_dependent <= dep_next;
      memory_result       <= result_next;
      memory_instr        <= instr_next;
      ld_addr             <= ld_addr_next;
      ld_instr            <= ld_instr_next;
      ld_dep              <= ld_dep_next;
    end
  end

`ifdef MAU_FAULT_EN
  // Fault flag is high only for the cycle its bundle is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_fault <= 1'b0;
    else       mem_fault <= fault_next;
  end
`else
  // Range checking compiled out: flag tied low, limit intentionally unused.
  logic unused_fault_cfg;
  assign unused_fault_cfg = fault_next ^ (^MEM_TOP);
  assign mem_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table-driven single-cycle
// vectors with a bundle scoreboard, plus hand sequences for loads, load
// followed by ALU op, reset during a load and the address-limit boundary.
module tb_mem_access_unit;

`ifdef MAU_FAULT_EN
  localparam logic [15:0] TB_MEM_TOP   = 16'h00FF;
  localparam int          EXP_WRITES   = 2;
`else
  localparam logic [15:0] TB_MEM_TOP   = 16'hFFFF;
  localparam int          EXP_WRITES   = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        execute_done, execute_is_dependent;
  logic [15:0] execute_result, execute_instr, execute_store_data;
  logic [15:0] mem_read_output;
  logic        mem_write;
  logic [15:0] mem_write_address, mem_write_input, mem_read_address;
  logic        memory_stall, memory_done, memory_is_dependent;
  logic [15:0] memory_result, memory_instr;
  logic        mem_fault;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  typedef struct packed {
    logic        done;
    logic        dep;
    logic [15:0] result;
    logic [15:0] instr;
    logic [15:0] sdata;
  } exe_t;

  typedef struct packed {
    logic        done;
    logic        dep;
    logic [15:0] result;
    logic [15:0] instr;
    logic        fault;
  } bundle_t;

  typedef struct packed {
    exe_t        in;
    logic        exp_write;
    logic [15:0] exp_waddr;
    logic [15:0] exp_wdata;
    bundle_t     exp_out;
  } vec_t;

  bundle_t sb_q[$];

  mem_access_unit #(
    .AW(16), .DW(16), .MEM_TOP(TB_MEM_TOP)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .execute_done        (execute_done),
    .execute_is_dependent(execute_is_dependent),
    .execute_result      (execute_result),
    .execute_instr       (execute_instr),
    .execute_store_data  (execute_store_data),
    .mem_read_output     (mem_read_output),
    .mem_write           (mem_write),
    .mem_write_address   (mem_write_address),
    .mem_write_input     (mem_write_input),
    .mem_read_address    (mem_read_address),
    .memory_stall        (memory_stall),
    .memory_done         (memory_done),
    .memory_is_dependent (memory_is_dependent),
    .memory_result       (memory_result),
    .memory_instr        (memory_instr),
    .mem_fault           (mem_fault)
  );

  always #5 clk = ~clk;

  // Memory contents: one preloaded word, a fixed pattern elsewhere.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a == 16'h0020) ? 16'h1234 : (a ^ 16'hA5C3);
  endfunction

  // Synchronous-read memory model and write-strobe counter.
  always @(posedge clk) begin
    mem_read_output <= mem_f(mem_read_address);
    if (mem_write) n_writes <= n_writes + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input exe_t b);
    execute_done         = b.done;
    execute_is_dependent = b.dep;
    execute_result       = b.result;
    execute_instr        = b.instr;
    execute_store_data   = b.sdata;
  endtask

  task automatic check_bundle(input string name, input bundle_t e);
    check({name, ".done"},   memory_done,         e.done);
    check({name, ".dep"},    memory_is_dependent, e.dep);
    check({name, ".result"}, memory_result,       e.result);
    check({name, ".instr"},  memory_instr,        e.instr);
    check({name, ".fault"},  mem_fault,           e.fault);
  endtask

  localparam exe_t BUBBLE = '{done:1'b0, dep:1'b0, result:16'h0, instr:16'h0, sdata:16'h0};

  vec_t    vecs[9];
  bundle_t exp_b;
  exe_t    ldr_b, add_b;
  logic    st;
  int      lat, stall_cyc;

  initial begin
    // Single-cycle operations: inputs, expected write port, expected bundle.
    vecs[0] = '{'{1,1,16'h0042,16'h1042,16'h0000}, 0, 16'h0, 16'h0, '{1,1,16'h0042,16'h1042,0}};
    vecs[1] = '{'{0,1,16'h0020,16'h6020,16'h0000}, 0, 16'h0, 16'h0, '{0,1,16'h0042,16'h1042,0}};
    vecs[2] = '{'{1,1,16'h0010,16'h7010,16'hBEEF}, 1, 16'h0010, 16'hBEEF, '{1,0,16'h0010,16'h7010,0}};
    vecs[3] = '{'{1,1,16'h1111,16'h5ABC,16'hDEAD}, 0, 16'h0, 16'h0, '{1,1,16'h1111,16'h5ABC,0}};
    vecs[4] = '{'{1,0,16'h2222,16'h8DEF,16'h0000}, 0, 16'h0, 16'h0, '{1,0,16'h2222,16'h8DEF,0}};
    vecs[5] = '{'{0,0,16'h0044,16'h7044,16'hCAFE}, 0, 16'h0, 16'h0, '{0,0,16'h2222,16'h8DEF,0}};
    vecs[6] = '{'{1,0,16'h00FF,16'h7FFF,16'hA5A5}, 1, 16'h00FF, 16'hA5A5, '{1,0,16'h00FF,16'h7FFF,0}};
    vecs[7] = '{'{1,1,16'h0000,16'h0000,16'h0000}, 0, 16'h0, 16'h0, '{1,1,16'h0000,16'h0000,0}};
    vecs[8] = '{'{1,0,16'hFFFF,16'hF00F,16'h0000}, 0, 16'h0, 16'h0, '{1,0,16'hFFFF,16'hF00F,0}};

    // Reset state, with a store and then a load presented during reset.
    reset = 1'b1;
    drive('{1,1,16'h0010,16'h7010,16'hBEEF});
    #3;
    check_bundle("reset", '{0,0,16'h0,16'h0,0});
    check("reset.mem_write", mem_write, 1'b0);
    check("reset.waddr", mem_write_address, 16'h0);
    drive('{1,1,16'h0020,16'h6020,16'h0});
    #1;
    check("reset.stall", memory_stall, 1'b0);
    check("reset.raddr", mem_read_address, 16'h0);
    drive(BUBBLE);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors: comb ports mid-cycle, bundle after the edge via queue.
    foreach (vecs[i]) begin
      drive(vecs[i].in);
      @(negedge clk);
      check($sformatf("v%0d.mem_write", i), mem_write, vecs[i].exp_write);
      check($sformatf("v%0d.stall", i), memory_stall, 1'b0);
      check($sformatf("v%0d.raddr", i), mem_read_address, 16'h0);
      if (vecs[i].exp_write) begin
        check($sformatf("v%0d.waddr", i), mem_write_address, vecs[i].exp_waddr);
        check($sformatf("v%0d.wdata", i), mem_write_input, vecs[i].exp_wdata);
      end
      sb_q.push_back(vecs[i].exp_out);
      @(posedge clk); #1;
      exp_b = sb_q.pop_front();
      check_bundle($sformatf("v%0d", i), exp_b);
    end
    drive(BUBBLE);
    @(posedge clk); #1;

    // Load then ALU op held behind the stall: bounded wait for the result.
    ldr_b = '{1,1,16'h0020,16'h6A20,16'h0};
    add_b = '{1,1,16'h0077,16'h2077,16'h0};
    drive(ldr_b);
    lat = 0;
    stall_cyc = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      st = memory_stall;
      if (st) stall_cyc++;
      if (c <= 2) begin
        check($sformatf("ld.raddr%0d", c), mem_read_address, 16'h0020);
        check($sformatf("ld.mem_write%0d", c), mem_write, 1'b0);
      end
      @(posedge clk); #1;
      if (!st) drive(add_b);
      if (memory_done) begin
        lat = c;
        break;
      end
    end
    check("ld.latency", lat, 2);
    check("ld.stall_cycles", stall_cyc, 1);
    check_bundle("ld", '{1,1,16'h1234,16'h6A20,0});
    @(negedge clk);
    check("ld_add.stall", memory_stall, 1'b0);
    check("ld_add.raddr", mem_read_address, 16'h0);
    @(posedge clk); #1;
    check_bundle("ld_add", '{1,1,16'h0077,16'h2077,0});
    drive(BUBBLE);
    @(posedge clk); #1;
    check("ld_add.no_dup", memory_done, 1'b0);

`ifdef MAU_FAULT_EN
    // Just above the limit: store and load are both suppressed and flagged.
    drive('{1,1,16'h0100,16'h7100,16'h5555});
    @(negedge clk);
    check("flt_str.mem_write", mem_write, 1'b0);
    @(posedge clk); #1;
    check_bundle("flt_str", '{1,0,16'h0,16'h7100,1});
    drive('{1,1,16'h0100,16'h6100,16'h0});
    @(negedge clk);
    check("flt_ldr.stall", memory_stall, 1'b0);
    @(posedge clk); #1;
    check_bundle("flt_ldr", '{1,0,16'h0,16'h6100,1});
    drive(BUBBLE);
    @(posedge clk); #1;
    check("flt.clear", mem_fault, 1'b0);
`else
    // Top of the address space is accessed verbatim.
    drive('{1,1,16'hFFFF,16'h7001,16'h0001});
    @(negedge clk);
    check("top_str.mem_write", mem_write, 1'b1);
    check("top_str.waddr", mem_write_address, 16'hFFFF);
    check("top_str.wdata", mem_write_input, 16'h0001);
    @(posedge clk); #1;
    check_bundle("top_str", '{1,0,16'hFFFF,16'h7001,0});
    drive(BUBBLE);
    @(posedge clk); #1;
`endif

    // Reset while waiting on a load: abort, then a fresh load from IDLE.
    drive('{1,1,16'h0030,16'h6030,16'h0});
    @(posedge clk); #1;
    #2;
    reset = 1'b1;
    #1;
    check_bundle("rst_ld", '{0,0,16'h0,16'h0,0});
    check("rst_ld.raddr", mem_read_address, 16'h0);
    check("rst_ld.stall", memory_stall, 1'b0);
    drive(BUBBLE);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ld.no_result", memory_done, 1'b0);
    drive('{1,0,16'h0030,16'h6031,16'h0});
    @(negedge clk);
    check("rst_ld.idle_stall", memory_stall, 1'b1);
    @(posedge clk); #1;
    check("rst_ld.bubble", memory_done, 1'b0);
    @(posedge clk); #1;
    check_bundle("rst_ld.reload", '{1,0,16'hA5F3,16'h6031,0});
    drive(BUBBLE);
    @(posedge clk); #1;

    check("write_strobes", n_writes, EXP_WRITES);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
